// File: rtl/fpu_sequencer.sv
// IDLE/BUSY/DONE issue controller for the multi-cycle FP units: captures an E-stage FP op,
// stalls the front end for the unit's fixed latency, then emits a one-cycle writeback pulse.
module fpu_sequencer #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 10,
  parameter int LAT_SQRT = 12,
  parameter int CW       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic [2:0]  fpu_cont,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd,
  input  logic        kill,
  output logic [2:0]  unit_op,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        unit_start,
  input  logic [31:0] unit_y,
  output logic        stall,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] res,
  output logic [4:0]  res_rd,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    unit_op_reg;
  logic [31:0]   unit_a_reg, unit_b_reg, res_reg;
  logic [4:0]    res_rd_reg;
  logic          unit_start_reg, err_reg;
  logic          capture, illegal;

  function automatic logic [CW-1:0] lat_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: lat_of = CW'(LAT_ADD);
      3'd2:       lat_of = CW'(LAT_MUL);
      3'd3:       lat_of = CW'(LAT_DIV);
      3'd4:       lat_of = CW'(LAT_SQRT);
      default:    lat_of = CW'(1);
    endcase
  endfunction

  assign capture = (state_reg == IDLE) && issue && !kill;
  assign illegal = (unit_op_reg > 3'd4);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      unit_op_reg    <= '0;
      unit_a_reg     <= '0;
      unit_b_reg     <= '0;
      res_reg        <= '0;
      res_rd_reg     <= '0;
      unit_start_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      unit_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (capture) begin
            unit_op_reg    <= fpu_cont;
            unit_a_reg     <= a;
            unit_b_reg     <= b;
            res_rd_reg     <= rd;
            cnt_reg        <= lat_of(fpu_cont);
            err_reg        <= 1'b0;
            unit_start_reg <= 1'b1;
            state_reg      <= BUSY;
          end
        end
        BUSY: begin
          if (kill) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
            // Last latency cycle: unit_y is valid now; illegal ops never drive a unit.
            if (cnt_reg == CW'(1)) begin
              res_reg   <= illegal ? 32'd0 : unit_y;
              err_reg   <= illegal;
              state_reg <= DONE;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Reset masks the combinational handshakes so nothing leaks out during the reset cycles.
  assign stall     = !reset && !kill &&
                     (((state_reg == IDLE) && issue) || (state_reg == BUSY));
  assign res_valid = !reset && !kill && (state_reg == DONE);
  assign err       = res_valid && err_reg;
  assign busy      = (state_reg != IDLE);

  assign unit_op    = unit_op_reg;
  assign unit_a     = unit_a_reg;
  assign unit_b     = unit_b_reg;
  assign unit_start = unit_start_reg;
  assign res        = res_reg;
  assign res_rd     = res_rd_reg;

endmodule
